// File: rtl/ar_beat_gen_if.sv
// AR request / per-beat address bundle between the read-request FIFO,
// the beat generator and the cache lookup stage.
interface ar_beat_gen_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ID_WIDTH-1:0]   req_id;
  logic [1:0]            req_burst;
  logic [2:0]            req_size;
  logic [7:0]            req_len;

  logic                  beat_valid;
  logic                  beat_ready;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [ID_WIDTH-1:0]   beat_id;
  logic [7:0]            beat_idx;
  logic                  beat_last;
  logic                  beat_err;

  modport slave (
    input  req_valid, req_addr, req_id, req_burst, req_size, req_len, beat_ready,
    output req_ready, beat_valid, beat_addr, beat_id, beat_idx, beat_last, beat_err
  );

  modport master (
    output req_valid, req_addr, req_id, req_burst, req_size, req_len, beat_ready,
    input  req_ready, beat_valid, beat_addr, beat_id, beat_idx, beat_last, beat_err
  );
endinterface

// File: rtl/ar_beat_gen.sv
// Expands one buffered AXI AR request into len+1 per-beat addresses
// (FIXED / INCR / WRAP) and flags protocol-illegal bursts.
module ar_beat_gen #(
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_BYTES = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  ar_beat_gen_if.slave bus
);
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t      ADDR_ZERO   = {ADDR_WIDTH{1'b0}};
  localparam addr_t      ADDR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2:0] SIZE_MAX    = 3'($clog2(DATA_BYTES));
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t                state_r, state_s;
  logic                  req_ready_s;
  logic                  accept_s;
  logic                  beat_hs_s;
  addr_t                 step_s;
  addr_t                 incr_next_s;
  addr_t                 wrap_next_s;
  addr_t                 next_addr_s;

  logic                  beat_valid_r;
  addr_t                 beat_addr_r;
  logic [ID_WIDTH-1:0]   beat_id_r;
  logic [7:0]            beat_idx_r;
  logic                  beat_last_r;
  logic                  beat_err_r;
  logic [1:0]            burst_r;
  logic [2:0]            size_r;
  logic [7:0]            len_r;
  addr_t                 wrap_lower_r;
  addr_t                 wrap_end_r;

  function automatic addr_t wrap_lower(input addr_t addr, input logic [2:0] size,
                                       input logic [7:0] len);
    addr_t wrap_bytes;
    wrap_bytes = (addr_t'(len) + ADDR_ONE) << size;
    return addr & ~(wrap_bytes - ADDR_ONE);
  endfunction

  function automatic addr_t wrap_end(input addr_t addr, input logic [2:0] size,
                                     input logic [7:0] len);
    return wrap_lower(addr, size, len) + ((addr_t'(len) + ADDR_ONE) << size);
  endfunction

  function automatic logic burst_err(input addr_t addr, input logic [1:0] burst,
                                     input logic [2:0] size, input logic [7:0] len);
    addr_t bytes;
    addr_t aligned;
    addr_t last_addr;
    logic  wrap_len_ok;
    bytes       = ADDR_ONE << size;
    aligned     = addr & ~(bytes - ADDR_ONE);
    last_addr   = (len == 8'd0) ? addr : aligned + (addr_t'(len) << size);
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == BURST_RSVD)
        || ((burst == BURST_WRAP) && !wrap_len_ok)
        || ((burst == BURST_WRAP) && ((addr & (bytes - ADDR_ONE)) != ADDR_ZERO))
        || (size > SIZE_MAX)
        || ((burst == 2'b01) && (addr[ADDR_WIDTH-1:12] != last_addr[ADDR_WIDTH-1:12]));
  endfunction

  // Next-state and pop strobe; the pop is suppressed while reset is held.
  always_comb begin
    state_s     = state_r;
    req_ready_s = 1'b0;
    beat_hs_s   = beat_valid_r && bus.beat_ready;
    case (state_r)
      ST_IDLE: begin
        req_ready_s = 1'b1;
        if (bus.req_valid) begin
          state_s = ST_BURST;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (beat_hs_s && beat_last_r) begin
          req_ready_s = 1'b1;
          state_s     = bus.req_valid ? ST_BURST : ST_IDLE;
        end else begin
          state_s = ST_BURST;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    req_ready_s = req_ready_s && rst_n;
    accept_s    = req_ready_s && bus.req_valid;
  end

  // Address of the following beat for the latched burst type.
  always_comb begin
    step_s      = ADDR_ONE << size_r;
    incr_next_s = (beat_addr_r & ~(step_s - ADDR_ONE)) + step_s;
    wrap_next_s = beat_addr_r + step_s;
    case (burst_r)
      BURST_FIXED: next_addr_s = beat_addr_r;
      BURST_WRAP:  next_addr_s = (wrap_next_s == wrap_end_r) ? wrap_lower_r : wrap_next_s;
      default:     next_addr_s = incr_next_s;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latch and beat output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_valid_r <= 1'b0;
      beat_addr_r  <= ADDR_ZERO;
      beat_id_r    <= {ID_WIDTH{1'b0}};
      beat_idx_r   <= 8'd0;
      beat_last_r  <= 1'b0;
      beat_err_r   <= 1'b0;
      burst_r      <= 2'b00;
      size_r       <= 3'd0;
      len_r        <= 8'd0;
      wrap_lower_r <= ADDR_ZERO;
      wrap_end_r   <= ADDR_ZERO;
    end else if (accept_s) begin
      beat_valid_r <= 1'b1;
      beat_addr_r  <= bus.req_addr;
      beat_id_r    <= bus.req_id;
      beat_idx_r   <= 8'd0;
      beat_last_r  <= (bus.req_len == 8'd0);
      beat_err_r   <= burst_err(bus.req_addr, bus.req_burst, bus.req_size, bus.req_len);
      burst_r      <= bus.req_burst;
      size_r       <= bus.req_size;
      len_r        <= bus.req_len;
      wrap_lower_r <= wrap_lower(bus.req_addr, bus.req_size, bus.req_len);
      wrap_end_r   <= wrap_end(bus.req_addr, bus.req_size, bus.req_len);
    end else if (beat_hs_s && !beat_last_r) begin
      beat_addr_r  <= next_addr_s;
      beat_idx_r   <= beat_idx_r + 8'd1;
      beat_last_r  <= ((beat_idx_r + 8'd1) == len_r);
    end else if (beat_hs_s) begin
      beat_valid_r <= 1'b0;
    end else begin
      beat_valid_r <= beat_valid_r;
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.beat_valid = beat_valid_r;
  assign bus.beat_addr  = beat_addr_r;
  assign bus.beat_id    = beat_id_r;
  assign bus.beat_idx   = beat_idx_r;
  assign bus.beat_last  = beat_last_r;
  assign bus.beat_err   = beat_err_r;
endmodule

// File: tb/tb_ar_beat_gen.sv
// Directed self-checking bench for ar_beat_gen: burst types, error flags,
// backpressure, back-to-back bursts and mid-burst reset.
module tb_ar_beat_gen;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [63:0] exp_a [256];

  ar_beat_gen_if #(.ADDR_WIDTH(64), .ID_WIDTH(4)) bus ();

  ar_beat_gen #(.ADDR_WIDTH(64), .ID_WIDTH(4), .DATA_BYTES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input logic [63:0] a0, input logic [63:0] a1,
                         input logic [63:0] a2, input logic [63:0] a3);
    exp_a[0] = a0;
    exp_a[1] = a1;
    exp_a[2] = a2;
    exp_a[3] = a3;
  endtask

  task automatic drive_req(input logic [63:0] addr, input logic [3:0] id,
                           input logic [1:0] burst, input logic [2:0] size,
                           input logic [7:0] len);
    bus.req_addr  = addr;
    bus.req_id    = id;
    bus.req_burst = burst;
    bus.req_size  = size;
    bus.req_len   = len;
    bus.req_valid = 1'b1;
  endtask

  task automatic check_beat(input string tag, input logic [63:0] addr, input int idx,
                            input logic last, input logic err, input logic [3:0] id);
    check_eq({tag, "_valid"}, 64'(bus.beat_valid), 64'd1);
    check_eq({tag, "_addr"},  bus.beat_addr, addr);
    check_eq({tag, "_idx"},   64'(bus.beat_idx), 64'(idx));
    check_eq({tag, "_last"},  64'(bus.beat_last), 64'(last));
    check_eq({tag, "_err"},   64'(bus.beat_err), 64'(err));
    check_eq({tag, "_id"},    64'(bus.beat_id), 64'(id));
  endtask

  // Accept one request from idle, then check every beat against exp_a with beat_ready=1.
  task automatic do_burst(input string tag, input logic [63:0] addr, input logic [3:0] id,
                          input logic [1:0] burst, input logic [2:0] size,
                          input logic [7:0] len, input logic err);
    @(posedge clk); #1;
    drive_req(addr, id, burst, size, len);
    @(negedge clk);
    check_eq({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    check_eq({tag, "_pre_valid"}, 64'(bus.beat_valid), 64'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      check_beat(tag, exp_a[i], i, (i == int'(len)), err, id);
    end
    @(negedge clk);
    check_eq({tag, "_done"}, 64'(bus.beat_valid), 64'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.beat_ready = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 64'd0;
    bus.req_id     = 4'd0;
    bus.req_burst  = 2'b00;
    bus.req_size   = 3'd0;
    bus.req_len    = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", 64'(bus.beat_valid), 64'd0);
    check_eq("rst_addr",  bus.beat_addr, 64'd0);
    check_eq("rst_id",    64'(bus.beat_id), 64'd0);
    check_eq("rst_idx",   64'(bus.beat_idx), 64'd0);
    check_eq("rst_last",  64'(bus.beat_last), 64'd0);
    check_eq("rst_err",   64'(bus.beat_err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_addr = 64'hABC0;
    repeat (3) @(negedge clk);
    check_eq("idle_novalid_beat", 64'(bus.beat_valid), 64'd0);
    check_eq("idle_req_ready",    64'(bus.req_ready), 64'd1);

    set_exp(64'h1000, 64'h1008, 64'h1010, 64'h1018);
    do_burst("incr", 64'h1000, 4'h1, 2'b01, 3'd3, 8'd3, 1'b0);
    set_exp(64'h1003, 64'h1004, 64'h1008, 64'h0);
    do_burst("incr_unal", 64'h1003, 4'h2, 2'b01, 3'd2, 8'd2, 1'b0);
    set_exp(64'h1010, 64'h1018, 64'h1000, 64'h1008);
    do_burst("wrap", 64'h1010, 4'h3, 2'b10, 3'd3, 8'd3, 1'b0);
    set_exp(64'h1010, 64'h1000, 64'h1008, 64'h0);
    do_burst("wrap_len2", 64'h1010, 4'h4, 2'b10, 3'd3, 8'd2, 1'b1);
    set_exp(64'h1014, 64'h101C, 64'h0, 64'h0);
    do_burst("wrap_unal", 64'h1014, 4'h6, 2'b10, 3'd3, 8'd1, 1'b1);
    set_exp(64'h2000, 64'h2000, 64'h2000, 64'h0);
    do_burst("fixed", 64'h2000, 4'h5, 2'b00, 3'd3, 8'd2, 1'b0);
    set_exp(64'hFF8, 64'h1000, 64'h0, 64'h0);
    do_burst("incr_4k", 64'hFF8, 4'h7, 2'b01, 3'd3, 8'd1, 1'b1);
    set_exp(64'h3000, 64'h3004, 64'h0, 64'h0);
    do_burst("rsvd", 64'h3000, 4'h8, 2'b11, 3'd2, 8'd1, 1'b1);
    set_exp(64'h4000, 64'h4010, 64'h0, 64'h0);
    do_burst("big_size", 64'h4000, 4'hA, 2'b01, 3'd4, 8'd1, 1'b1);
    set_exp(64'h5000, 64'h0, 64'h0, 64'h0);
    do_burst("len0", 64'h5000, 4'hB, 2'b01, 3'd3, 8'd0, 1'b0);
    for (int i = 0; i < 256; i++) exp_a[i] = 64'(i);
    do_burst("len255", 64'h0, 4'hC, 2'b01, 3'd0, 8'd255, 1'b0);

    // Backpressure on beat 1, with a second request queued for back-to-back.
    @(posedge clk); #1;
    drive_req(64'h6000, 4'h1, 2'b01, 3'd3, 8'd3);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_beat("bp_b0", 64'h6000, 0, 1'b0, 1'b0, 4'h1);
    @(posedge clk); #1;
    bus.beat_ready = 1'b0;
    drive_req(64'h7000, 4'h9, 2'b01, 3'd3, 8'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_beat("bp_hold", 64'h6008, 1, 1'b0, 1'b0, 4'h1);
      check_eq("bp_req_ready", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.beat_ready = 1'b1;
    @(negedge clk);
    check_beat("bp_b1", 64'h6008, 1, 1'b0, 1'b0, 4'h1);
    @(negedge clk);
    check_beat("bp_b2", 64'h6010, 2, 1'b0, 1'b0, 4'h1);
    @(negedge clk);
    check_beat("bp_b3", 64'h6018, 3, 1'b1, 1'b0, 4'h1);
    check_eq("b2b_req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check_eq("b2b_ready_drop", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    check_beat("b2b_b0", 64'h7000, 0, 1'b0, 1'b0, 4'h9);
    @(negedge clk);
    check_beat("b2b_b1", 64'h7008, 1, 1'b1, 1'b0, 4'h9);
    @(negedge clk);
    check_eq("b2b_done", 64'(bus.beat_valid), 64'd0);

    // Reset asserted while beat 2 of a len=7 burst is presented.
    @(posedge clk); #1;
    drive_req(64'h8000, 4'h2, 2'b01, 3'd3, 8'd7);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_beat("mr_b0", 64'h8000, 0, 1'b0, 1'b0, 4'h2);
    @(negedge clk);
    check_beat("mr_b1", 64'h8008, 1, 1'b0, 1'b0, 4'h2);
    @(negedge clk);
    check_beat("mr_b2", 64'h8010, 2, 1'b0, 1'b0, 4'h2);
    rst_n = 1'b0;
    drive_req(64'h9100, 4'hD, 2'b01, 3'd3, 8'd1);
    #1;
    check_eq("mr_no_pop", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    check_eq("mr_valid", 64'(bus.beat_valid), 64'd0);
    check_eq("mr_addr",  bus.beat_addr, 64'd0);
    check_eq("mr_id",    64'(bus.beat_id), 64'd0);
    check_eq("mr_idx",   64'(bus.beat_idx), 64'd0);
    check_eq("mr_last",  64'(bus.beat_last), 64'd0);
    check_eq("mr_err",   64'(bus.beat_err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    set_exp(64'h9000, 64'h9008, 64'h0, 64'h0);
    do_burst("post_rst", 64'h9000, 4'h3, 2'b01, 3'd3, 8'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
